vpu_sp_line_eval: RTL and testbench

- Sprite line evaluator; sits directly upstream of the sprite pixel pipeline.
- During the blanking/param window it scans every sprite's data0 word in sprite parameter RAM and tests vertical overlap with the target line.
- It writes the indices of up to LIST_MAX hitting sprites into a per-line list RAM; the downstream parameter loader and pipeline consume that list.
- Fixed-latency scan, so the VPU line sequencer can schedule it against line_cycle.

---
 rtl/vpu_sp_line_eval.sv | 167 ++++++++++++++++
 tb/tb_vpu_sp_line_eval.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_sp_line_eval.sv
// Sprite line evaluator: scans every sprite's data0 word and lists the sprites overlapping the target line.
// Latency: fixed SP_NUM+3 cycles from the accepted start edge to the done pulse.
// Backpressure: none; the parameter RAM and list RAM are single-cycle, and start is ignored while busy or done.
module vpu_sp_line_eval #(
    parameter int SP_NUM      = 128,
    parameter int SP_IDX_W    = 7,
    parameter int PARAM_SIZE  = 5,
    parameter int SP_ADDR_W   = 10,
    parameter int LIST_MAX    = 16,
    parameter int LIST_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             line_y,
    output logic                   param_en,
    output logic [SP_ADDR_W-1:0]   param_addr,
    input  logic [31:0]            param_dout,
    output logic                   list_we,
    output logic [LIST_ADDR_W-1:0] list_waddr,
    output logic [SP_IDX_W-1:0]    list_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [LIST_ADDR_W:0]   count,
    output logic                   overflow
);

    // One extra bit so the counter can run past the last issue into the drain cycles.
    localparam int CYC_W = SP_IDX_W + 1;
    localparam logic [CYC_W-1:0]       ISSUE_END = CYC_W'(SP_NUM);
    localparam logic [CYC_W-1:0]       SCAN_LAST = CYC_W'(SP_NUM + 1);
    localparam logic [LIST_ADDR_W:0]   LIST_FULL = (LIST_ADDR_W + 1)'(LIST_MAX);
    localparam logic [SP_ADDR_W-1:0]   ENTRY_STRIDE = SP_ADDR_W'(PARAM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CYC_W-1:0]     cyc;
    logic [7:0]           y_q;
    logic                 rd_vld;
    logic [SP_IDX_W-1:0]  rd_idx;
    logic                 start_acc;

    logic                 sp_en;
    logic [1:0]           sp_tsz;
    logic [7:0]           sp_y;
    logic [7:0]           sp_dy;
    logic [7:0]           sp_h;
    logic                 hit;
    logic                 unused_dout;

    // Start is only honoured from IDLE; any start during SCAN or DONE is dropped.
    assign start_acc = (state_q == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs; SCAN covers SP_NUM issue cycles plus 2 drain cycles.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (cyc == SCAN_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan cycle counter: value k-1 during scan cycle k, doubles as the sprite index being issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= '0;
        end else if (start_acc) begin
            cyc <= '0;
        end else if (state_q == S_SCAN) begin
            cyc <= cyc + 1'b1;
        end
    end

    // Target line is captured once per scan so line_y may change freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else if (start_acc) begin
            y_q <= line_y;
        end
    end

    // One data0 read per sprite; address stays 0 when idle so the RAM port is quiet.
    always_comb begin
        param_en   = (state_q == S_SCAN) && (cyc < ISSUE_END);
        param_addr = '0;
        if (param_en) param_addr = SP_ADDR_W'(cyc) * ENTRY_STRIDE;
    end

    // Track which sprite the RAM is returning this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else begin
            rd_vld <= param_en;
            rd_idx <= cyc[SP_IDX_W-1:0];
        end
    end

    // Vertical overlap test; 8-bit subtraction wraps so sprites straddling line 255/0 still hit.
    always_comb begin
        sp_en  = param_dout[31];
        sp_tsz = param_dout[25:24];
        sp_y   = param_dout[7:0];
        sp_dy  = y_q - sp_y;
        sp_h   = 8'd8 << sp_tsz;
        hit    = rd_vld && sp_en && (sp_dy < sp_h);
    end

    // Remaining data0 fields (afen and friends) do not affect line selection.
    assign unused_dout = ^{param_dout[30:26], param_dout[23:8]};

    // List writer: hits land in ascending index order; once full, further hits only flag overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            list_we    <= 1'b0;
            list_waddr <= '0;
            list_wdata <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            list_we <= 1'b0;
            if (start_acc) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (hit) begin
                if (count < LIST_FULL) begin
                    list_we    <= 1'b1;
                    list_waddr <= count[LIST_ADDR_W-1:0];
                    list_wdata <= rd_idx;
                    count      <= count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vpu_sp_line_eval.sv
// Bench for the sprite line evaluator: parameter RAM model, per-cycle observer and a reference line list.
// Latency: checks the fixed 131-cycle scan, issue addresses and list-write cycles.
// Backpressure: none; the bench exercises ignored starts and asynchronous reset mid-scan.
module tb_vpu_sp_line_eval;

    localparam int SP_NUM     = 128;
    localparam int PARAM_SIZE = 5;
    localparam int LIST_MAX   = 16;
    localparam int DONE_CYC   = SP_NUM + 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  line_y;
    logic        param_en;
    logic [9:0]  param_addr;
    logic [31:0] param_dout;
    logic        list_we;
    logic [3:0]  list_waddr;
    logic [6:0]  list_wdata;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        overflow;

    vpu_sp_line_eval dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .line_y     (line_y),
        .param_en   (param_en),
        .param_addr (param_addr),
        .param_dout (param_dout),
        .list_we    (list_we),
        .list_waddr (list_waddr),
        .list_wdata (list_wdata),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parameter RAM: registered read, data valid the cycle after param_en.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (param_en) param_dout <= mem[param_addr];
    end

    int total = 0;
    int bad   = 0;

    // Observations from the most recent scan.
    int   wr_k[$];
    int   wr_a[$];
    int   wr_d[$];
    int   done_k;
    int   issue_bad;
    int   cnt_d;
    logic ovf_d;
    int   cnt_after;
    logic ovf_after;
    logic done_after;
    logic busy_after;
    logic [15:0] rst_snap;

    // Reference list: sprite indices hitting the line, in priority order.
    int exp_q[$];

    function automatic void build_model(input logic [7:0] y);
        logic [31:0] w;
        int dy;
        int h;
        exp_q.delete();
        for (int i = 0; i < SP_NUM; i++) begin
            w = mem[i * PARAM_SIZE];
            if (w[31]) begin
                dy = (int'(y) - int'(w[7:0]) + 256) % 256;
                h  = 8 * (1 << w[25:24]);
                if (dy < h) exp_q.push_back(i);
            end
        end
    endfunction

    task automatic clear_sprites();
        logic [31:0] r;
        for (int a = 0; a < 1024; a++) begin
            r = $urandom;
            if (a % PARAM_SIZE == 0) r[31] = 1'b0;
            mem[a] = r;
        end
    endtask

    task automatic set_sp(input int i, input logic en, input logic [1:0] ts, input logic [7:0] y);
        logic [31:0] r;
        r = $urandom;
        r[31]    = en;
        r[25:24] = ts;
        r[7:0]   = y;
        mem[i * PARAM_SIZE] = r;
    endtask

    // Drive one scan and record what the DUT did each cycle. spur_k injects a start pulse in
    // cycle spur_k; rst_k asserts reset in cycle rst_k and abandons the scan.
    task automatic run_scan(input logic [7:0] y, input int spur_k, input int rst_k);
        int exp_addr;
        logic exp_en;
        wr_k.delete(); wr_a.delete(); wr_d.delete();
        done_k = 0; issue_bad = 0; cnt_d = -1; ovf_d = 1'bx;
        @(negedge clk);
        start  = 1'b1;
        line_y = y;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == spur_k);
            if (k == spur_k) line_y = ~y;
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                rst_snap = {busy, param_en, list_we, done, count, overflow, 5'd0};
                repeat (2) @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            exp_en   = (k <= SP_NUM);
            exp_addr = (k - 1) * PARAM_SIZE;
            if (param_en !== exp_en) issue_bad++;
            else if (exp_en && param_addr !== exp_addr[9:0]) issue_bad++;
            if (busy !== (k <= SP_NUM + 2)) issue_bad++;
            if (list_we === 1'b1) begin
                wr_k.push_back(k);
                wr_a.push_back(int'(list_waddr));
                wr_d.push_back(int'(list_wdata));
            end
            if (done === 1'b1) begin
                done_k = k;
                cnt_d  = int'(count);
                ovf_d  = overflow;
                break;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        cnt_after  = int'(count);
        ovf_after  = overflow;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; line_y = 8'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({param_en, param_addr, list_we, list_waddr, list_wdata, busy, done, count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b addr=%0d we=%b busy=%b done=%b count=%0d ovf=%b, want all 0",
                     param_en, param_addr, list_we, busy, done, count, overflow);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({param_en, list_we, busy, done} !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got en=%b we=%b busy=%b done=%b, want 0 0 0 0",
                     param_en, list_we, busy, done);
        end
    endtask

    // Hand-derived single-sprite cases: index, enable, tilesize, sp_y, line, expected hit.
    task automatic test_patterns();
        int          t_idx [8] = '{5, 0, 0, 0, 2, 2, 2, 9};
        logic        t_en  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [1:0]  t_ts  [8] = '{0, 1, 1, 3, 1, 1, 1, 2};
        logic [7:0]  t_spy [8] = '{100, 100, 100, 100, 250, 250, 250, 60};
        logic [7:0]  t_ln  [8] = '{103, 115, 116, 163, 5, 10, 249, 70};
        int          t_hit [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
        for (int c = 0; c < 8; c++) begin
            clear_sprites();
            set_sp(t_idx[c], t_en[c], t_ts[c], t_spy[c]);
            run_scan(t_ln[c], 0, 0);
            total++;
            if (done_k !== DONE_CYC) begin
                bad++; $display("FAIL pat%0d_done_cycle: got %0d, want %0d", c, done_k, DONE_CYC);
            end
            total++;
            if (cnt_d !== t_hit[c] || ovf_d !== 1'b0) begin
                bad++; $display("FAIL pat%0d_count: got count=%0d ovf=%b, want count=%0d ovf=0", c, cnt_d, ovf_d, t_hit[c]);
            end
            total++;
            if (wr_k.size() !== t_hit[c]) begin
                bad++; $display("FAIL pat%0d_nwrites: got %0d, want %0d", c, wr_k.size(), t_hit[c]);
            end else if (t_hit[c] == 1 &&
                         (wr_k[0] !== t_idx[c] + 3 || wr_a[0] !== 0 || wr_d[0] !== t_idx[c])) begin
                bad++;
                $display("FAIL pat%0d_write: got cycle=%0d waddr=%0d wdata=%0d, want cycle=%0d waddr=0 wdata=%0d",
                         c, wr_k[0], wr_a[0], wr_d[0], t_idx[c] + 3, t_idx[c]);
            end
            total++;
            if (issue_bad !== 0) begin
                bad++; $display("FAIL pat%0d_issue: got %0d bad issue/busy cycles, want 0", c, issue_bad);
            end
        end
    endtask

    task automatic setup_overflow();
        clear_sprites();
        for (int i = 0; i < 20; i++) set_sp(i, 1'b1, 2'd0, 8'(50 - $urandom_range(0, 7)));
        // Disabled sprites overlapping the line must not count.
        for (int i = 20; i < 30; i++) set_sp(i, 1'b0, 2'd3, 8'd40);
    endtask

    task automatic test_overflow();
        int mism;
        setup_overflow();
        run_scan(8'd50, 0, 0);
        total++;
        if (done_k !== DONE_CYC) begin
            bad++; $display("FAIL ovf_done_cycle: got %0d, want %0d", done_k, DONE_CYC);
        end
        total++;
        if (cnt_d !== LIST_MAX || ovf_d !== 1'b1) begin
            bad++; $display("FAIL ovf_count: got count=%0d ovf=%b, want count=16 ovf=1", cnt_d, ovf_d);
        end
        mism = 0;
        for (int j = 0; j < wr_k.size() && j < LIST_MAX; j++)
            if (wr_k[j] !== j + 3 || wr_a[j] !== j || wr_d[j] !== j) mism++;
        total++;
        if (wr_k.size() !== LIST_MAX || mism !== 0) begin
            bad++; $display("FAIL ovf_writes: got %0d writes with %0d wrong, want 16 writes of index 0..15", wr_k.size(), mism);
        end
        total++;
        if (cnt_after !== LIST_MAX || ovf_after !== 1'b1 || done_after !== 1'b0) begin
            bad++; $display("FAIL ovf_hold: got count=%0d ovf=%b done=%b after done, want 16 1 0", cnt_after, ovf_after, done_after);
        end
    endtask

    task automatic test_back_to_back();
        // Start during busy with a line that has no hits: must be ignored.
        setup_overflow();
        run_scan(8'd50, 20, 0);
        total++;
        if (done_k !== DONE_CYC || cnt_d !== LIST_MAX || ovf_d !== 1'b1) begin
            bad++; $display("FAIL busy_start_ignored: got done@%0d count=%0d ovf=%b, want done@%0d count=16 ovf=1",
                            done_k, cnt_d, ovf_d, DONE_CYC);
        end
        // Start asserted in the done cycle: must not launch a scan.
        run_scan(8'd50, DONE_CYC, 0);
        total++;
        if (busy_after !== 1'b0 || done_k !== DONE_CYC) begin
            bad++; $display("FAIL done_start_ignored: got busy=%b after done (done@%0d), want busy=0 done@%0d",
                            busy_after, done_k, DONE_CYC);
        end
        // A new accepted start clears count and overflow.
        run_scan(8'd200, 0, 0);
        total++;
        if (cnt_d !== 0 || ovf_d !== 1'b0 || wr_k.size() !== 0) begin
            bad++; $display("FAIL restart_clears: got count=%0d ovf=%b writes=%0d, want 0 0 0", cnt_d, ovf_d, wr_k.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] y;
        int exp_n;
        int mism;
        for (int it = 0; it < 5; it++) begin
            clear_sprites();
            for (int i = 0; i < SP_NUM; i++)
                set_sp(i, ($urandom_range(0, 3) <= it), 2'($urandom_range(0, 3)), 8'($urandom));
            y = 8'($urandom);
            build_model(y);
            exp_n = (exp_q.size() > LIST_MAX) ? LIST_MAX : exp_q.size();
            run_scan(y, 0, 0);
            total++;
            if (done_k !== DONE_CYC) begin
                bad++; $display("FAIL rnd%0d_done_cycle: got %0d, want %0d", it, done_k, DONE_CYC);
            end
            total++;
            if (cnt_d !== exp_n || ovf_d !== (exp_q.size() > LIST_MAX)) begin
                bad++; $display("FAIL rnd%0d_count: got count=%0d ovf=%b, want count=%0d ovf=%b (hits=%0d)",
                                it, cnt_d, ovf_d, exp_n, exp_q.size() > LIST_MAX, exp_q.size());
            end
            mism = 0;
            for (int j = 0; j < wr_k.size() && j < exp_n; j++)
                if (wr_k[j] !== exp_q[j] + 3 || wr_a[j] !== j || wr_d[j] !== exp_q[j]) mism++;
            total++;
            if (wr_k.size() !== exp_n || mism !== 0) begin
                bad++; $display("FAIL rnd%0d_writes: got %0d writes with %0d wrong, want %0d", it, wr_k.size(), mism, exp_n);
            end
            total++;
            if (issue_bad !== 0) begin
                bad++; $display("FAIL rnd%0d_issue: got %0d bad issue/busy cycles, want 0", it, issue_bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        setup_overflow();
        run_scan(8'd50, 0, 40);
        total++;
        if (rst_snap !== 16'd0) begin
            bad++; $display("FAIL reset_mid_async: got busy/en/we/done/count/ovf snapshot %h, want 0", rst_snap);
        end
        repeat (5) @(negedge clk);
        total++;
        if ({param_en, list_we, busy, done} !== 4'b0) begin
            bad++; $display("FAIL reset_mid_quiet: got en=%b we=%b busy=%b done=%b, want 0 0 0 0",
                            param_en, list_we, busy, done);
        end
        run_scan(8'd50, 0, 0);
        total++;
        if (done_k !== DONE_CYC || cnt_d !== LIST_MAX || ovf_d !== 1'b1 || issue_bad !== 0) begin
            bad++; $display("FAIL reset_mid_rescan: got done@%0d count=%0d ovf=%b issue_bad=%0d, want done@%0d 16 1 0",
                            done_k, cnt_d, ovf_d, issue_bad, DONE_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
